// File: rtl/ss_cmd_rx.sv
// Serial command receiver: synchronises a three-wire link, decodes 8-bit frames and
// turns each one into a jump pulse or a burst of advance pulses for the step counter.
module ss_cmd_rx #(
  parameter int TIMEOUT_W   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scs_n,
  input  logic       sclk,
  input  logic       sdat,
  output logic       adv,
  output logic       jmp,
  output logic [5:0] tgt,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_DRAIN} rx_state_t;
  typedef enum logic [1:0] {EX_IDLE, EX_ADV, EX_JMP} ex_state_t;

  logic [SYNC_STAGES-1:0] scs_q, sclk_q, sdat_q, vld_q;
  logic                   sclk_prev;
  logic                   scs_s, sclk_s, sdat_s, sync_ok, sclk_rise;

  rx_state_t              rx_state, rx_next;
  logic [6:0]             shreg, sh_next;
  logic [2:0]             bitcnt, bit_next;
  logic [TIMEOUT_W-1:0]   tocnt, to_next;
  logic                   armed, armed_next;
  logic                   cmd_done, rx_err;
  logic [7:0]             cmd;

  ex_state_t              ex_state, ex_next;
  logic [6:0]             burst, burst_next;
  logic                   adv_next, jmp_next, busy_next, err_next;
  logic [5:0]             tgt_next;

  // vld_q marks when the synchronised scs_n reflects a real pin sample rather than its reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scs_q     <= '1;
      sclk_q    <= '0;
      sdat_q    <= '0;
      vld_q     <= '0;
      sclk_prev <= 1'b0;
    end else begin
      scs_q     <= {scs_q[SYNC_STAGES-2:0], scs_n};
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sdat_q    <= {sdat_q[SYNC_STAGES-2:0], sdat};
      vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
    end
  end

  assign scs_s     = scs_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign sdat_s    = sdat_q[SYNC_STAGES-1];
  assign sync_ok   = vld_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cmd       = {shreg, sdat_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      tocnt    <= '0;
      armed    <= 1'b0;
    end else begin
      rx_state <= rx_next;
      shreg    <= sh_next;
      bitcnt   <= bit_next;
      tocnt    <= to_next;
      armed    <= armed_next;
    end
  end

  // A frame may only start after scs_n has genuinely been seen high, so a frame already
  // in flight when reset releases is never decoded.
  always_comb begin
    rx_next    = rx_state;
    sh_next    = shreg;
    bit_next   = bitcnt;
    to_next    = tocnt;
    armed_next = armed;
    cmd_done   = 1'b0;
    rx_err     = 1'b0;
    if (scs_s && sync_ok) armed_next = 1'b1;
    case (rx_state)
      RX_IDLE: begin
        bit_next = '0;
        to_next  = '0;
        if (armed && !scs_s) begin
          rx_next    = RX_SHIFT;
          armed_next = 1'b0;
        end
      end
      RX_SHIFT: begin
        if (scs_s) begin
          rx_next = RX_IDLE;
          rx_err  = 1'b1;
        end else if (sclk_rise) begin
          sh_next  = {shreg[5:0], sdat_s};
          bit_next = bitcnt + 3'd1;
          to_next  = '0;
          if (bitcnt == 3'd7) begin
            cmd_done = 1'b1;
            rx_next  = RX_DRAIN;
          end
        end else if (&tocnt) begin
          rx_err  = 1'b1;
          rx_next = RX_DRAIN;
        end else begin
          to_next = tocnt + 1'b1;
        end
      end
      RX_DRAIN: begin
        if (scs_s) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_state <= EX_IDLE;
      burst    <= '0;
      adv      <= 1'b0;
      jmp      <= 1'b0;
      tgt      <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ex_state <= ex_next;
      burst    <= burst_next;
      adv      <= adv_next;
      jmp      <= jmp_next;
      tgt      <= tgt_next;
      busy     <= busy_next;
      err      <= err_next;
    end
  end

  // Commands arriving while a burst or jump is in progress are dropped and flagged
  always_comb begin
    ex_next    = ex_state;
    burst_next = burst;
    adv_next   = 1'b0;
    jmp_next   = 1'b0;
    tgt_next   = tgt;
    err_next   = rx_err;
    case (ex_state)
      EX_IDLE: begin
        if (cmd_done) begin
          case (cmd[7:6])
            2'b01: begin
              burst_next = {1'b0, cmd[5:0]} + 7'd1;
              adv_next   = 1'b1;
              ex_next    = EX_ADV;
            end
            2'b10: begin
              tgt_next = cmd[5:0];
              jmp_next = 1'b1;
              ex_next  = EX_JMP;
            end
            2'b11:   err_next = 1'b1;
            default: ;
          endcase
        end
      end
      EX_ADV: begin
        if (cmd_done) err_next = 1'b1;
        if (burst == 7'd1) begin
          ex_next = EX_IDLE;
        end else begin
          burst_next = burst - 7'd1;
          adv_next   = 1'b1;
        end
      end
      EX_JMP: begin
        if (cmd_done) err_next = 1'b1;
        ex_next = EX_IDLE;
      end
      default: ex_next = EX_IDLE;
    endcase
    busy_next = adv_next | jmp_next;
  end

endmodule

// File: tb/tb_ss_cmd_rx.sv
// Directed bench for ss_cmd_rx: bit-bangs frames on the pins and checks pulse counts,
// cycle-exact latencies and output invariants against hand-computed values.
module tb_ss_cmd_rx;

  logic       clk;
  logic       rst_n;
  logic       scs_n;
  logic       sclk;
  logic       sdat;
  logic       adv;
  logic       jmp;
  logic [5:0] tgt;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int adv_cnt = 0, jmp_cnt = 0, err_cnt = 0, adv_runs = 0;
  int both_cnt = 0, busy_bad = 0, tgt_bad = 0;
  int first_adv_cyc = 0, last_adv_cyc = 0, last_jmp_cyc = 0, last_err_cyc = 0;
  int last_jmp_tgt = 0;
  logic       adv_prev = 1'b0;
  logic [5:0] tgt_prev = 6'd0;

  int b_adv, b_jmp, b_err, b_runs;
  int t8, t8a, s;

  ss_cmd_rx #(.TIMEOUT_W(4), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .scs_n(scs_n),
    .sclk (sclk),
    .sdat (sdat),
    .adv  (adv),
    .jmp  (jmp),
    .tgt  (tgt),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample on the falling edge, well away from the registering edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (adv) begin
      adv_cnt++;
      last_adv_cyc = cyc;
      if (!adv_prev) begin
        adv_runs++;
        first_adv_cyc = cyc;
      end
    end
    adv_prev = adv;
    if (jmp) begin
      jmp_cnt++;
      last_jmp_cyc = cyc;
      last_jmp_tgt = int'(tgt);
    end
    if (err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (adv && jmp) both_cnt++;
    if (busy !== (adv | jmp)) busy_bad++;
    if (tgt !== tgt_prev && !jmp) tgt_bad++;
    tgt_prev = tgt;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic takeSnapshot();
    b_adv  = adv_cnt;
    b_jmp  = jmp_cnt;
    b_err  = err_cnt;
    b_runs = adv_runs;
  endtask

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sends the low n bits MSB first; framed wraps them in an scs_n low/high pair
  task automatic applyStimulus(input logic [15:0] bits, input int n, input bit framed);
    if (framed) begin
      scs_n = 1'b0;
      waitCycles(4);
    end
    for (int i = 0; i < n; i++) begin
      sdat = bits[n-1-i];
      waitCycles(3);
      sclk = 1'b1;
      if (i == 7) t8 = cyc;
      waitCycles(3);
      sclk = 1'b0;
    end
    if (framed) begin
      waitCycles(1);
      scs_n = 1'b1;
      waitCycles(4);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    scs_n = 1'b1;
    sclk  = 1'b0;
    sdat  = 1'b0;
    waitCycles(2);
    for (int i = 0; i < 12; i++) begin
      scs_n = i[0];
      sclk  = i[1];
      sdat  = i[2];
      waitCycles(1);
    end
    checkOutput("reset_outputs", int'({adv, jmp, tgt, busy, err}), 0);
    checkOutput("reset_pulses", adv_cnt + jmp_cnt + err_cnt, 0);

    // Release with scs_n already low: this frame must not be decoded
    scs_n = 1'b0;
    sclk  = 1'b0;
    sdat  = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(4);
    takeSnapshot();
    applyStimulus(16'h0081, 8, 1'b0);
    waitCycles(6);
    checkOutput("stale_frame_jmp", jmp_cnt - b_jmp, 0);
    checkOutput("stale_frame_err", err_cnt - b_err, 0);
    scs_n = 1'b1;
    waitCycles(4);

    $display("[TB] jump to 45");
    takeSnapshot();
    applyStimulus(16'h00AD, 8, 1'b1);
    waitCycles(4);
    checkOutput("jmp_count", jmp_cnt - b_jmp, 1);
    checkOutput("jmp_latency", last_jmp_cyc, t8 + 3);
    checkOutput("jmp_tgt", last_jmp_tgt, 45);
    checkOutput("jmp_no_adv", adv_cnt - b_adv, 0);
    checkOutput("jmp_no_err", err_cnt - b_err, 0);
    checkOutput("tgt_hold", int'(tgt), 45);

    $display("[TB] advance arg 0");
    takeSnapshot();
    applyStimulus(16'h0040, 8, 1'b1);
    waitCycles(2);
    checkOutput("adv1_count", adv_cnt - b_adv, 1);
    checkOutput("adv1_latency", first_adv_cyc, t8 + 3);
    checkOutput("adv1_no_jmp", jmp_cnt - b_jmp, 0);

    $display("[TB] advance arg 63");
    takeSnapshot();
    applyStimulus(16'h007F, 8, 1'b1);
    waitCycles(62);
    checkOutput("adv64_count", adv_cnt - b_adv, 64);
    checkOutput("adv64_runs", adv_runs - b_runs, 1);
    checkOutput("adv64_first", first_adv_cyc, t8 + 3);
    checkOutput("adv64_last", last_adv_cyc, t8 + 66);
    checkOutput("adv64_no_jmp", jmp_cnt - b_jmp, 0);

    $display("[TB] overrun during burst");
    takeSnapshot();
    applyStimulus(16'h007F, 8, 1'b1);
    t8a = t8;
    applyStimulus(16'h0085, 8, 1'b1);
    waitCycles(6);
    checkOutput("ovr_adv_count", adv_cnt - b_adv, 64);
    checkOutput("ovr_adv_runs", adv_runs - b_runs, 1);
    checkOutput("ovr_no_jmp", jmp_cnt - b_jmp, 0);
    checkOutput("ovr_err_count", err_cnt - b_err, 1);
    checkOutput("ovr_err_cycle", last_err_cyc, t8a + 60);
    checkOutput("ovr_tgt_kept", int'(tgt), 45);

    $display("[TB] reserved and nop");
    takeSnapshot();
    applyStimulus(16'h00C5, 8, 1'b1);
    waitCycles(2);
    checkOutput("rsv_err_count", err_cnt - b_err, 1);
    checkOutput("rsv_err_cycle", last_err_cyc, t8 + 3);
    checkOutput("rsv_no_out", (adv_cnt - b_adv) + (jmp_cnt - b_jmp), 0);
    takeSnapshot();
    applyStimulus(16'h0005, 8, 1'b1);
    waitCycles(2);
    checkOutput("nop_quiet", (adv_cnt - b_adv) + (jmp_cnt - b_jmp) + (err_cnt - b_err), 0);

    $display("[TB] short frame");
    takeSnapshot();
    applyStimulus(16'h0015, 5, 1'b1);
    waitCycles(2);
    checkOutput("short_err", err_cnt - b_err, 1);
    checkOutput("short_no_out", (adv_cnt - b_adv) + (jmp_cnt - b_jmp), 0);

    $display("[TB] timeout");
    takeSnapshot();
    scs_n = 1'b0;
    s = cyc;
    waitCycles(16);
    checkOutput("to_not_early", err_cnt - b_err, 0);
    waitCycles(14);
    checkOutput("to_err", err_cnt - b_err, 1);
    applyStimulus(16'h0081, 8, 1'b0);
    scs_n = 1'b1;
    waitCycles(4);
    checkOutput("to_drain_no_jmp", jmp_cnt - b_jmp, 0);
    checkOutput("to_drain_one_err", err_cnt - b_err, 1);

    $display("[TB] back-to-back");
    takeSnapshot();
    applyStimulus(16'h0077, 8, 1'b1);
    t8a = t8;
    applyStimulus(16'h008A, 8, 1'b1);
    waitCycles(4);
    checkOutput("b2b_adv_count", adv_cnt - b_adv, 56);
    checkOutput("b2b_adv_last", last_adv_cyc, t8a + 58);
    checkOutput("b2b_jmp_count", jmp_cnt - b_jmp, 1);
    checkOutput("b2b_jmp_cycle", last_jmp_cyc, t8a + 60);
    checkOutput("b2b_no_err", err_cnt - b_err, 0);
    checkOutput("b2b_tgt", int'(tgt), 10);

    $display("[TB] extra bits");
    takeSnapshot();
    applyStimulus(16'h083A, 12, 1'b1);
    waitCycles(2);
    checkOutput("extra_jmp_count", jmp_cnt - b_jmp, 1);
    checkOutput("extra_jmp_cycle", last_jmp_cyc, t8 + 3);
    checkOutput("extra_tgt", int'(tgt), 3);
    checkOutput("extra_no_err", err_cnt - b_err, 0);

    checkOutput("adv_jmp_exclusive", both_cnt, 0);
    checkOutput("busy_tracks", busy_bad, 0);
    checkOutput("tgt_stable", tgt_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ss_cmd_rx.md
# ss_cmd_rx

Serial command receiver that drives the control inputs of the 6-bit loadable step counter (`adv`, `jmp`, `in[5:0]`). It sits directly upstream of the counter. It synchronises a three-wire serial link (`scs_n`, `sclk`, `sdat`) from board pins and decodes 8-bit command frames. Each decoded frame becomes either a single-cycle jump pulse or a burst of advance pulses in the `clk` domain.

## Interface

- `TIMEOUT_W`, default 16: width of the frame-timeout counter. A frame aborts after 2^TIMEOUT_W−1 cycles with no accepted bit.
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchroniser. Legal values are 2 and 3.

Ports:

- `clk`, in, 1: single system clock. All logic is in this domain.
- `rst_n`, in, 1: asynchronous, active-low reset. Release is synchronous to `clk`.
- `scs_n`, in, 1: async frame select, active low.
- `sclk`, in, 1: async serial bit clock.
- `sdat`, in, 1: async serial data. Sampled on the `sclk` rising edge, MSB first.
- `adv`, out, 1: advance request to the counter.
- `jmp`, out, 1: jump request to the counter.
- `tgt`, out, 6: jump target. Drives the counter's `in`.
- `busy`, out, 1: high while an advance burst or jump is being issued.
- `err`, out, 1: one-cycle pulse on any frame error or overrun.

## Operation

- **Synchronisers.** `scs_n`, `sclk` and `sdat` each pass through SYNC_STAGES flops. A one-flop history on synchronised `sclk` gives the rising edge.
- **Bit accept.** A bit is accepted in a cycle where synced `sclk` has a rising edge, synced `scs_n` = 0, and the receiver is in SHIFT. Synced `sdat` is shifted in, and a 3-bit bit counter increments.
- **Frame format.** `cmd[7:6]` is the opcode and `cmd[5:0]` is `arg`.
  - 00: NOP. Frame completes with no output.
  - 01: ADV. Issues arg+1 consecutive `adv` pulses, so 1..64 pulses.
  - 10: JMP. `tgt` = arg, with `jmp` high for one cycle.
  - 11: reserved. Drop the frame and pulse `err`.
- **Receiver FSM.**
  - IDLE: go to SHIFT when synced `scs_n` falls. Clear the bit counter and the timeout counter.
  - SHIFT: accept bits. Go to DRAIN on the 8th accept; the command is complete in that cycle. Go to IDLE and pulse `err` if `scs_n` rises with fewer than 8 bits. Go to DRAIN and pulse `err` on timeout.
  - DRAIN: ignore all `sclk` edges. Go to IDLE when synced `scs_n` = 1.
- **Timeout counter.** Resets on each accept and on entry to SHIFT. Saturating. Compares against all-ones.
- **Executor.** A separate FSM with states EX_IDLE, EX_ADV and EX_JMP.
  - Takes a completed command only in EX_IDLE.
  - If a command completes while the executor is not idle, the command is dropped and `err` pulses (overrun). The executor is not disturbed.
  - The burst counter is 7 bits, loaded with arg+1, and decrements per `adv` cycle.
- **Output invariants.**
  - `adv` and `jmp` are never high in the same cycle.
  - `tgt` changes only when a JMP starts and holds its value otherwise.
  - `busy` = `adv` | `jmp`.
- **Reset values.**
  - Outputs: `adv` = 0, `jmp` = 0, `tgt` = 6'd0, `busy` = 0, `err` = 0.
  - Internal state: receiver in IDLE, executor in EX_IDLE.
  - Synchronisers are reset to idle line levels: `scs_n` = 1, `sclk` = 0, `sdat` = 0.
- **Reset during a frame or burst.** Reset aborts immediately. After release, a frame already in progress on the pins is not decoded. The receiver waits for a fresh `scs_n` fall, which requires `scs_n` to be seen high first.

## Timing

- **Input latency.** From a pin edge to the bit-accept cycle is SYNC_STAGES+1 `clk` cycles. `sclk` high and low phases must each be ≥ SYNC_STAGES+1 `clk` periods. `sdat` must be stable for that long around the `sclk` rise.
- **Outputs.** All outputs are registered.
- **Command timing.** Let T be the 8th accept cycle.
  - JMP: `jmp` = 1 and `tgt` = arg in cycle T+1 only.
  - ADV: `adv` = 1 in cycles T+1 through T+1+arg.
  - NOP and reserved: no `adv`/`jmp`. The reserved-opcode `err` pulse is in T+1.
- **Error pulses.** Overrun, abort and timeout errors each pulse `err` in the cycle after detection.
- **Back-to-back commands.** A command completing in the cycle after the previous burst's last `adv` is accepted.
- **Bit counter wrap.** The counter covers 0..7. The 8th accept forces DRAIN, so no ninth bit is ever shifted.

## Test plan

- **Reset.** Hold `rst_n`=0 while toggling all pins → all outputs 0. After release with `scs_n`=0 already low → no command until `scs_n` goes 1 then 0.
- **JMP.** Send frame 8'b10_101101 → exactly one `jmp` cycle at T+1 with `tgt`=6'd45. `adv` never asserts. `tgt` holds 45 afterwards.
- **ADV burst extremes.**
  - Send 8'b01_000000 → 1 `adv` cycle.
  - Send 8'b01_111111 → 64 contiguous `adv` cycles with `busy` high throughout.
  - `jmp` stays 0 in both cases.
- **Overrun.** Start ADV arg=63, then complete a JMP frame mid-burst → `err` pulses once. The burst still totals 64 cycles. No `jmp` is issued.
- **Short frame and timeout.**
  - Raise `scs_n` after 5 bits → `err` pulse, no output.
  - With TIMEOUT_W=4, hold `scs_n` low with no `sclk` for 15 cycles → `err`. Later `sclk` edges are ignored until `scs_n`=1.
- **Extra bits.** Send a 12-bit frame whose first 8 bits are 8'b10_000011 → `jmp` with `tgt`=3 at T+1. The 4 extra bits are ignored and `err` stays 0.
